// File: rtl/disp_arb_pkg.sv
// Shared constants, FSM state encoding and display saturation helper for the
// display arbiter.
package disp_arb_pkg;

  localparam int         NREQ     = 4;
  localparam logic [7:0] MAX_DISP = 8'd99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // The 2-digit display cannot show anything above 99.
  function automatic logic [7:0] sat_disp(input logic [7:0] v);
    return (v > MAX_DISP) ? MAX_DISP : v;
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running tick counter: tick is high for the cycle in which the count
// equals TICK_MAX; a synchronous clear holds the count at zero.
module disp_tick_gen #(
  parameter int TICK_MAX = 49_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Four-requester display arbiter: grants the 2-digit display for DWELL_TICKS
// ticks, then a one-cycle GAP. Define DISP_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins) instead of the default round-robin.
//
// Handshake: req[i] is a level request; the grant holds while req[i] stays high
// and ends either on the final dwell tick (done[i] pulses in the following GAP
// cycle) or one edge after req[i] drops (no done pulse).
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter int TICK_MAX    = 49_999_999,
  parameter int DWELL_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  output logic [3:0]  gnt,
  output logic [3:0]  done
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cur;
  logic [1:0] winner;
  logic [1:0] sel;
  logic [3:0] dwell_cnt;
  logic       tick;
  logic       final_tick;
  logic       tick_clr;

  // The counter is held clear outside GRANT, so it starts at 0 on GRANT entry.
  assign tick_clr = (state != GRANT);

  disp_tick_gen #(
    .TICK_MAX (TICK_MAX)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign final_tick = tick && (dwell_cnt == 4'(DWELL_TICKS - 1));

`ifdef DISP_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) winner = 2'(k);
    end
  end
`else
  logic [1:0] last_gnt;
  logic [1:0] rr_idx;
  logic       rr_found;

  // Search starts one past the previous winner and wraps modulo NREQ.
  always_comb begin
    winner   = last_gnt;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = 2'(int'(last_gnt) + k);
      if (!rr_found && req[rr_idx]) begin
        winner   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 2'd3;
    end else if (state == IDLE && req != 4'b0000) begin
      last_gnt <= winner;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 4'b0000) state_nxt = GRANT;
      GRANT:   if (!req[cur] || final_tick) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt        = '0;
    disp_valid = 1'b0;
    if (state == GRANT) begin
      gnt        = 4'b0001 << cur;
      disp_valid = 1'b1;
    end
  end

  // Display source is the incoming winner on the IDLE->GRANT edge, else the holder.
  assign sel = (state == IDLE) ? winner : cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      dwell_cnt <= '0;
      done      <= '0;
      disp_data <= '0;
    end else begin
      if (state == IDLE && req != 4'b0000) cur <= winner;

      if (state != GRANT)  dwell_cnt <= '0;
      else if (tick)       dwell_cnt <= dwell_cnt + 4'd1;

      done <= (state == GRANT && req[cur] && final_tick) ? (4'b0001 << cur) : 4'b0000;

      disp_data <= (state_nxt == GRANT) ? sat_disp(data[{sel, 3'b000} +: 8]) : 8'd0;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Table-driven bench for disp_arbiter (TICK_MAX=3, DWELL_TICKS=2: 8-cycle dwell)
// with a hand-written asynchronous reset-mid-grant sequence.
module tb_disp_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic [3:0]  gnt;
  logic [3:0]  done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        valid;
    logic [7:0]  dd;
    logic [3:0]  done;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];

  disp_arbiter #(
    .TICK_MAX    (3),
    .DWELL_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .gnt        (gnt),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, input logic [3:0] rq, input logic [31:0] d,
                     input logic [3:0] g, input logic v, input logic [7:0] dd,
                     input logic [3:0] dn);
    vec_t t;
    t.rst = r; t.req = rq; t.data = d; t.gnt = g; t.valid = v; t.dd = dd; t.done = dn;
    vecs.push_back(t);
  endtask

  task automatic add_grant(input logic [3:0] rq, input logic [31:0] d, input int idx,
                           input logic [7:0] dd, input int n);
    for (int k = 0; k < n; k++) add(1'b0, rq, d, 4'b0001 << idx, 1'b1, dd, 4'b0000);
  endtask

  task automatic add_idle(input bit r, input logic [3:0] rq, input logic [31:0] d);
    add(r, rq, d, 4'b0000, 1'b0, 8'd0, 4'b0000);
  endtask

  initial begin
    logic [16:0] e;
    int          idx;

    rst_n = 1'b0;
    req   = '0;
    data  = '0;

    // Single request with a mid-grant data change, done pulse, GAP, IDLE, regrant.
    add_idle(1'b1, 4'b0000, 32'd0);
    add_grant(4'b0001, 32'd42, 0, 8'd42, 2);
    add_grant(4'b0001, 32'd50, 0, 8'd50, 6);
    add(1'b0, 4'b0001, 32'd50, 4'b0000, 1'b0, 8'd0, 4'b0001);
    add_idle(1'b0, 4'b0001, 32'd50);
    add_grant(4'b0001, 32'd50, 0, 8'd50, 1);

    // All four requesting: rotation 0,1,2,3,0 (fixed priority: always 0).
    add_idle(1'b1, 4'b0000, 32'd0);
    for (int i = 0; i < 5; i++) begin
`ifdef DISP_ARB_FIXED_PRIO_EN
      idx = 0;
`else
      idx = i % 4;
`endif
      add_grant(4'b1111, 32'h0D0C0B0A, idx, 8'(10 + idx), 8);
      add(1'b0, 4'b1111, 32'h0D0C0B0A, 4'b0000, 1'b0, 8'd0, 4'b0001 << idx);
      add_idle(1'b0, 4'b1111, 32'h0D0C0B0A);
    end

    // Saturation at the 99 boundary, then request drop ends the grant without done.
    add_idle(1'b1, 4'b0000, 32'd0);
    add_grant(4'b0100, {8'd0, 8'd200, 16'd0}, 2, 8'd99, 1);
    add_grant(4'b0100, {8'd0, 8'd7,   16'd0}, 2, 8'd7,  1);
    add_grant(4'b0100, {8'd0, 8'd99,  16'd0}, 2, 8'd99, 1);
    add_grant(4'b0100, {8'd0, 8'd100, 16'd0}, 2, 8'd99, 1);
    add_idle(1'b0, 4'b0000, {8'd0, 8'd100, 16'd0});
    add_idle(1'b0, 4'b0000, 32'd0);

    // Early drop of req0 during grant cycle 3, requester 1 then granted.
    add_idle(1'b1, 4'b0000, 32'd0);
    add_grant(4'b0011, 32'h00000605, 0, 8'd5, 3);
    add_idle(1'b0, 4'b0010, 32'h00000605);
    add_idle(1'b0, 4'b0010, 32'h00000605);
    add_grant(4'b0010, 32'h00000605, 1, 8'd6, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = !vecs[i].rst;
      req   = vecs[i].req;
      data  = vecs[i].data;
      exp_q.push_back({vecs[i].gnt, vecs[i].valid, vecs[i].dd, vecs[i].done});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("gnt[%0d]", i),        32'(gnt),        32'(e[16:13]));
      check($sformatf("disp_valid[%0d]", i), 32'(disp_valid), 32'(e[12]));
      check($sformatf("disp_data[%0d]", i),  32'(disp_data),  32'(e[11:4]));
      check($sformatf("done[%0d]", i),       32'(done),       32'(e[3:0]));
    end

    // Asynchronous reset in grant cycle 5, then a fresh grant to requester 1.
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0001;
    data  = 32'h0000_1B2A;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_gnt", 32'(gnt), 32'h1);
    check("pre_rst_data", 32'(disp_data), 32'd42);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt",   32'(gnt),        32'h0);
    check("async_rst_valid", 32'(disp_valid), 32'h0);
    check("async_rst_data",  32'(disp_data),  32'h0);
    check("async_rst_done",  32'(done),       32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0010;
    @(posedge clk);
    #1;
    check("post_rst_gnt",  32'(gnt),       32'h2);
    check("post_rst_data", 32'(disp_data), 32'd27);
    check("post_rst_done", 32'(done),      32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
